imem_responder: RTL and testbench

//   Instruction-memory responder: the memory-side end of the fetch/instruction-memory

---
 rtl/imem_responder_pkg.sv | 26 ++
 rtl/imem_responder_if.sv | 21 ++
 rtl/imem_responder_array.sv | 26 ++
 rtl/imem_responder.sv | 99 +++++++++
 tb/tb_imem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_responder_pkg;

  // RV32 addi x0,x0,0, returned for misaligned or out-of-range fetches.
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } imem_state_e;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] addr;
    logic        err;
  } imem_rsp_t;

  // Word index of a byte address relative to the program base (modular subtraction).
  function automatic logic [31:0] imem_index(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch / program-load bus between the fetch stage (master) and the responder (slave).
interface imem_responder_if;
  logic [31:0] instr_addr_in;
  logic [31:0] instr_dat_out;
  logic        instr_dat_v;
  logic [31:0] resp_addr;
  logic        instr_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_dat;

  modport master (
    output instr_addr_in, prog_we, prog_addr, prog_dat,
    input  instr_dat_out, instr_dat_v, resp_addr, instr_err
  );

  modport slave (
    input  instr_addr_in, prog_we, prog_addr, prog_dat,
    output instr_dat_out, instr_dat_v, resp_addr, instr_err
  );
endinterface

// File: rtl/imem_responder_array.sv
// Program store: synchronous single-read/single-write array, read-before-write, no reset.
module imem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdat_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdat_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdat_q;

  // Read sees the contents before any write on the same edge.
  always_ff @(posedge clk_i) begin
    if (re_i) rdat_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdat_i;
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch address, returns the program word
// (or NOP with error) LATENCY cycles later and holds it while the address is held.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = IMEM_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  imem_state_e    state_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    cur_addr_q;
  logic           valid_q;
  logic           from_arr_q;
  imem_rsp_t      rsp_q;

  logic           accept_d;
  logic           rd_fire_d;
  logic           rd_bad_d;
  logic           rd_en_d;
  logic           wr_en_d;
  logic [31:0]    rd_addr_d;
  logic [31:0]    rd_idx_d;
  logic [31:0]    wr_idx_d;
  logic [31:0]    arr_rdat;

  // Acceptance, read-edge selection and range/alignment checks.
  // The array is read on the edge that ends the cycle where the decremented count
  // reaches zero (cnt_q==1), so its registered output lands exactly LATENCY cycles
  // after acceptance; with LATENCY=1 that is the acceptance edge itself.
  always_comb begin
    accept_d  = (state_q == IDLE) || (bus.instr_addr_in != cur_addr_q);
    rd_addr_d = accept_d ? bus.instr_addr_in : cur_addr_q;
    rd_idx_d  = imem_index(rd_addr_d, BASE_ADDR);
    rd_bad_d  = (rd_addr_d[1:0] != 2'b00) || (rd_idx_d >= DEPTH);
    rd_fire_d = accept_d ? (LATENCY == 1)
                         : ((state_q == BUSY) && (cnt_q == CW'(1)));
    rd_en_d   = rd_fire_d && !rd_bad_d && rst_n;
    wr_idx_d  = imem_index(bus.prog_addr, BASE_ADDR);
    wr_en_d   = bus.prog_we && rst_n && (wr_idx_d < DEPTH);
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .re_i    (rd_en_d),
    .raddr_i (rd_idx_d[AW-1:0]),
    .rdat_o  (arr_rdat),
    .we_i    (wr_en_d),
    .waddr_i (wr_idx_d[AW-1:0]),
    .wdat_i  (bus.prog_dat)
  );

  // Request FSM, latency counter and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      valid_q    <= 1'b0;
      from_arr_q <= 1'b0;
      rsp_q      <= '0;
    end else begin
      if (accept_d) begin
        cur_addr_q <= bus.instr_addr_in;
        cnt_q      <= CW'(LATENCY - 1);
        valid_q    <= 1'b0;
        state_q    <= (LATENCY == 1) ? DONE : BUSY;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_q <= DONE;
      end
      if (rd_fire_d) begin
        valid_q    <= 1'b1;
        from_arr_q <= !rd_bad_d;
        rsp_q.addr <= rd_addr_d;
        rsp_q.err  <= rd_bad_d;
        rsp_q.dat  <= rd_bad_d ? NOP_WORD : '0;
      end
    end
  end

  assign bus.instr_dat_v   = valid_q;
  assign bus.resp_addr     = rsp_q.addr;
  assign bus.instr_err     = rsp_q.err;
  assign bus.instr_dat_out = from_arr_q ? arr_rdat : rsp_q.dat;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1/2/3, one with a small DEPTH)
// share one stimulus stream and are compared every cycle with a run-length model.
module tb_imem_responder;

  localparam int unsigned ND = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        pwe;
  logic [31:0] paddr;
  logic [31:0] pdat;

  always #5 clk = ~clk;

  imem_responder_if bus0();
  imem_responder_if bus1();
  imem_responder_if bus2();

  assign bus0.instr_addr_in = addr;
  assign bus0.prog_we       = pwe;
  assign bus0.prog_addr     = paddr;
  assign bus0.prog_dat      = pdat;
  assign bus1.instr_addr_in = addr;
  assign bus1.prog_we       = pwe;
  assign bus1.prog_addr     = paddr;
  assign bus1.prog_dat      = pdat;
  assign bus2.instr_addr_in = addr;
  assign bus2.prog_we       = pwe;
  assign bus2.prog_addr     = paddr;
  assign bus2.prog_dat      = pdat;

  imem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  imem_responder #(.DEPTH(64),   .LATENCY(2)) u_l2 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  imem_responder #(.DEPTH(1024), .LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [31:0] o_dat  [ND];
  logic [31:0] o_addr [ND];
  logic        o_v    [ND];
  logic        o_err  [ND];

  assign o_dat[0]  = bus0.instr_dat_out;
  assign o_addr[0] = bus0.resp_addr;
  assign o_v[0]    = bus0.instr_dat_v;
  assign o_err[0]  = bus0.instr_err;
  assign o_dat[1]  = bus1.instr_dat_out;
  assign o_addr[1] = bus1.resp_addr;
  assign o_v[1]    = bus1.instr_dat_v;
  assign o_err[1]  = bus1.instr_err;
  assign o_dat[2]  = bus2.instr_dat_out;
  assign o_addr[2] = bus2.resp_addr;
  assign o_v[2]    = bus2.instr_dat_v;
  assign o_err[2]  = bus2.instr_err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  // Reference model state, one slot per instance.
  int unsigned lat  [ND];
  int unsigned dep  [ND];
  int unsigned run  [ND];
  logic [31:0] last [ND];
  logic        ev   [ND];
  logic        clean[ND];
  logic [31:0] edat [ND];
  logic [31:0] eaddr[ND];
  logic        eerr [ND];
  logic [31:0] mmem [ND][1024];
  logic [31:0] w_init [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %08h expected %08h", tag, cyc, got, exp);
    end
  endtask

  // A response appears once the same address has been sampled on LATENCY consecutive
  // non-reset edges; its data is the memory as it stood before that edge's write.
  task automatic model_edge();
    logic [31:0] idx;
    logic [31:0] widx;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        run[d]   = 0;
        ev[d]    = 1'b0;
        clean[d] = 1'b1;
        edat[d]  = '0;
        eaddr[d] = '0;
        eerr[d]  = 1'b0;
      end else begin
        if (run[d] != 0 && addr == last[d]) begin
          if (run[d] < 100) run[d]++;
        end else begin
          run[d] = 1;
        end
        last[d] = addr;
        if (run[d] == lat[d]) begin
          idx      = addr >> 2;
          ev[d]    = 1'b1;
          clean[d] = 1'b0;
          eaddr[d] = addr;
          eerr[d]  = (addr[1:0] != 2'b00) || (idx >= dep[d]);
          edat[d]  = eerr[d] ? 32'h0000_0013 : mmem[d][idx[9:0]];
        end else if (run[d] < lat[d]) begin
          ev[d] = 1'b0;
        end
        widx = paddr >> 2;
        if (pwe && widx < dep[d]) mmem[d][widx[9:0]] = pdat;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("valid[%0d]", d), 32'(o_v[d]), 32'(ev[d]));
      if (ev[d] || clean[d]) begin
        chk($sformatf("dat[%0d]", d),  o_dat[d],  edat[d]);
        chk($sformatf("addr[%0d]", d), o_addr[d], eaddr[d]);
        chk($sformatf("err[%0d]", d),  32'(o_err[d]), 32'(eerr[d]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int unsigned r;
    lat[0] = 1;    lat[1] = 2;  lat[2] = 3;
    dep[0] = 1024; dep[1] = 64; dep[2] = 1024;
    for (int d = 0; d < ND; d++) begin
      run[d] = 0; last[d] = '0; ev[d] = 1'b0; clean[d] = 1'b1;
      edat[d] = '0; eaddr[d] = '0; eerr[d] = 1'b0;
    end
    w_init[0] = 32'h0050_0093; w_init[1] = 32'h0060_0113;
    w_init[2] = 32'h0020_81B3; w_init[3] = 32'h0000_006F;
    w_init[4] = 32'h1234_5678; w_init[5] = 32'h0BAD_F00D;
    w_init[6] = 32'hA5A5_5A5A; w_init[7] = 32'h0F0F_F0F0;

    // Reset with outputs checked against zero.
    rst_n = 1'b0; addr = 32'h2; pwe = 1'b0; paddr = '0; pdat = '0;
    cycle();
    cycle();

    // Preload while fetching a misaligned address (array never read).
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pwe   = 1'b1;
      paddr = 32'(i) << 2;
      pdat  = (i < 8) ? w_init[i] : $urandom();
      cycle();
    end
    pwe = 1'b0;

    // Back-to-back fetch after reset release.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr = 32'(k) << 2;
      cycle();
      chk("l1_seq_valid", 32'(o_v[0]), 32'd1);
      chk("l1_seq_dat", o_dat[0], w_init[k]);
      chk("l1_seq_addr", o_addr[0], addr);
    end

    // Hold 0x8 on the LATENCY=3 instance.
    addr = 32'h8;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k < 3) chk("l3_hold_valid_low", 32'(o_v[2]), 32'd0);
      else begin
        chk("l3_hold_valid_high", 32'(o_v[2]), 32'd1);
        chk("l3_hold_dat", o_dat[2], w_init[2]);
      end
    end

    // 0x4 abandoned after one cycle, then 0x8.
    addr = 32'h4; cycle();
    chk("l3_abort_valid", 32'(o_v[2]), 32'd0);
    addr = 32'h8;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k < 3) chk("l3_restart_valid_low", 32'(o_v[2]), 32'd0);
      else begin
        chk("l3_restart_valid_high", 32'(o_v[2]), 32'd1);
        chk("l3_restart_dat", o_dat[2], w_init[2]);
      end
    end

    // Misaligned and one-past-the-end fetches.
    for (int t = 0; t < 2; t++) begin
      addr = (t == 0) ? 32'h6 : 32'h1000;
      for (int k = 1; k <= 3; k++) begin
        cycle();
        if (k == 1) chk("l1_bad_err", 32'(o_err[0]), 32'd1);
        if (k == 3) begin
          chk("l3_bad_valid", 32'(o_v[2]), 32'd1);
          chk("l3_bad_dat", o_dat[2], 32'h0000_0013);
          chk("l3_bad_err", 32'(o_err[2]), 32'd1);
        end
      end
    end

    // Write in the acceptance cycle is seen; write in the read cycle is not.
    addr = 32'h20; cycle();
    addr = 32'h10; pwe = 1'b1; paddr = 32'h10; pdat = 32'hDEAD_BEEF; cycle();
    pwe = 1'b0; cycle();
    chk("l2_wr_accept_dat", o_dat[1], 32'hDEAD_BEEF);
    addr = 32'h14; cycle();
    pwe = 1'b1; paddr = 32'h14; pdat = 32'hCAFE_F00D; cycle();
    chk("l2_wr_read_dat", o_dat[1], w_init[5]);
    pwe = 1'b0; cycle(); cycle();
    chk("l2_held_dat", o_dat[1], w_init[5]);
    addr = 32'h18; cycle();
    addr = 32'h14; cycle(); cycle();
    chk("l2_new_dat", o_dat[1], 32'hCAFE_F00D);

    // Reset while BUSY, with a write attempted during reset.
    addr = 32'h8; cycle();
    rst_n = 1'b0; pwe = 1'b1; paddr = 32'h0; pdat = 32'hBAD0_BAD0; cycle();
    chk("l3_rst_valid", 32'(o_v[2]), 32'd0);
    chk("l3_rst_dat", o_dat[2], 32'd0);
    chk("l3_rst_addr", o_addr[2], 32'd0);
    rst_n = 1'b1; pwe = 1'b0; addr = 32'h0;
    for (int k = 1; k <= 3; k++) cycle();
    chk("l3_post_rst_dat", o_dat[2], w_init[0]);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      r = $urandom_range(99);
      if (r < 55) addr = addr;
      else if (r < 85) addr = 32'($urandom_range(71)) << 2;
      else if (r < 92) addr = (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
      else if (r < 96) addr = 32'h1000 + (32'($urandom_range(3)) << 2);
      else addr = 32'hFFFF_FFFC;
      pwe   = ($urandom_range(99) < 20);
      paddr = ($urandom_range(9) == 0) ? 32'h1000 + (32'($urandom_range(7)) << 2)
                                       : (32'($urandom_range(79)) << 2) | 32'($urandom_range(3));
      pdat  = $urandom();
      cycle();
    end
    pwe = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
